ddr3_cache_port_arbiter: RTL and testbench

//  Shares the single AXI4 burst master of the DDR3 cache controller among NUM_REQ requesters.

---
 rtl/ddr3_cache_arb_pkg.sv | 29 ++
 rtl/ddr3_cache_port_arbiter_if.sv | 40 ++++
 rtl/ddr3_cache_rr_pick.sv | 20 ++
 rtl/ddr3_cache_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ddr3_cache_port_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_cache_arb_pkg.sv
// Shared types and the round-robin selection helper for the DDR3 cache port arbiter.
package ddr3_cache_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    DRAIN
  } arb_state_e;

  localparam int RR_MAX = 16;

  // Returns {valid, index}: first set bit at or after ptr, wrapping at num (num <= 16, ptr < num).
  function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  num);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(num)) idx = idx - int'(num);
      if ((k < int'(num)) && !res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr3_cache_port_arbiter_if.sv
// Requester and burst-engine signal bundle; slave is the arbiter side, master the environment side.
interface ddr3_cache_port_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT_W = 16
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_error;
  logic                      eng_start;
  logic                      eng_wr;
  logic [ADDR_W-1:0]         eng_addr;
  logic [LEN_W-1:0]          eng_len;
  logic                      eng_done;
  logic                      eng_error;
  logic [TIMEOUT_W-1:0]      timeout_cfg;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic                      eng_hung;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, eng_done, eng_error, timeout_cfg,
    output req_ready, req_done, req_error, eng_start, eng_wr, eng_addr, eng_len,
           grant_id, busy, eng_hung
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len, eng_done, eng_error, timeout_cfg,
    input  req_ready, req_done, req_error, eng_start, eng_wr, eng_addr, eng_len,
           grant_id, busy, eng_hung
  );

endinterface

// File: rtl/ddr3_cache_rr_pick.sv
// Combinational round-robin picker: first pending request at or after ptr, wrapping.
module ddr3_cache_rr_pick
  import ddr3_cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [4:0] res;

  assign res   = rr_pick(16'(req), 4'(ptr), 5'(NUM_REQ));
  assign idx   = res[IDX_W-1:0];
  assign valid = res[4];

endmodule

// File: rtl/ddr3_cache_port_arbiter.sv
// Round-robin sharing of the single AXI4 burst master among NUM_REQ requesters, with watchdog.
module ddr3_cache_port_arbiter
  import ddr3_cache_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input logic                    ACLK,
  input logic                    ARESETN,
  ddr3_cache_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx;
  logic                 pick_valid;
  logic                 eng_wr_q, eng_wr_d;
  logic [ADDR_W-1:0]    eng_addr_q, eng_addr_d;
  logic [LEN_W-1:0]     eng_len_q, eng_len_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_dec;
  logic                 wdog_en_q, wdog_en_d, err_q, err_d, to_flag_q, to_flag_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d, req_done_q, req_done_d;
  logic [NUM_REQ-1:0]   req_error_q, req_error_d, grant_oh;
  logic                 eng_start_q, eng_start_d, busy_q, busy_d, eng_hung_q, eng_hung_d;
  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [LEN_W-1:0]     len_arr  [NUM_REQ];

  ddr3_cache_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      len_arr[i]  = bus.req_len[i*LEN_W +: LEN_W];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      eng_wr_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_len_q   <= '0;
      wdog_q      <= '0;
      wdog_en_q   <= 1'b0;
      err_q       <= 1'b0;
      to_flag_q   <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      req_error_q <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      eng_hung_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      eng_wr_q    <= eng_wr_d;
      eng_addr_q  <= eng_addr_d;
      eng_len_q   <= eng_len_d;
      wdog_q      <= wdog_d;
      wdog_en_q   <= wdog_en_d;
      err_q       <= err_d;
      to_flag_q   <= to_flag_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
      req_error_q <= req_error_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
      eng_hung_q  <= eng_hung_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    eng_wr_d   = eng_wr_q;
    eng_addr_d = eng_addr_q;
    eng_len_d  = eng_len_q;
    wdog_d     = wdog_q;
    wdog_en_d  = wdog_en_q;
    err_d      = err_q;
    to_flag_d  = to_flag_q;
    wdog_dec   = wdog_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          eng_wr_d   = bus.req_wr[pick_idx];
          eng_addr_d = addr_arr[pick_idx];
          eng_len_d  = len_arr[pick_idx];
          state_d    = START;
        end
      end
      START: begin
        wdog_d    = bus.timeout_cfg;
        wdog_en_d = |bus.timeout_cfg;
        if (bus.eng_done) begin
          err_d   = bus.eng_error;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      // A completion in the expiry cycle takes priority over the timeout.
      WAIT: begin
        if (bus.eng_done) begin
          err_d   = bus.eng_error;
          state_d = RESP;
        end else if (wdog_en_q) begin
          wdog_d = wdog_dec;
          if (wdog_dec == '0) begin
            err_d     = 1'b1;
            to_flag_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;
        state_d  = to_flag_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.eng_done) begin
          to_flag_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with state_q.
  always_comb begin
    grant_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_d;
    req_ready_d = (state_d == START) ? grant_oh : '0;
    req_done_d  = (state_d == RESP) ? grant_oh : '0;
    req_error_d = ((state_d == RESP) && err_d) ? grant_oh : '0;
    eng_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
    eng_hung_d  = (state_d == DRAIN);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.req_done  = req_done_q;
  assign bus.req_error = req_error_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_wr    = eng_wr_q;
  assign bus.eng_addr  = eng_addr_q;
  assign bus.eng_len   = eng_len_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.eng_hung  = eng_hung_q;

endmodule

// File: tb/tb_ddr3_cache_port_arbiter.sv
// Directed bench for ddr3_cache_port_arbiter: arbitration order, errors, watchdog and reset.
module tb_ddr3_cache_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 8;
  localparam int TIMEOUT_W = 16;

  logic ACLK = 1'b0;
  logic ARESETN;
  int   checks = 0;
  int   failures = 0;
  int   ready_pulses = 0;
  int   p0;

  ddr3_cache_port_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)
  ) bus ();

  ddr3_cache_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (bus.req_ready != '0) ready_pulses++;

  task automatic step(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic done, input logic err);
    bus.req_valid = valid;
    bus.eng_done  = done;
    bus.eng_error = err;
  endtask

  task automatic setReq(input int i, input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bus.req_wr[i]                   = wr;
    bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.req_len[i*LEN_W +: LEN_W]    = len;
  endtask

  initial begin
    ARESETN         = 1'b0;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.timeout_cfg = 16'd100;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(2);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_start", bus.eng_start, 0);
    checkOutput("rst_grant", bus.grant_id, 0);
    checkOutput("rst_addr", bus.eng_addr, 0);
    checkOutput("rst_len", bus.eng_len, 0);
    checkOutput("rst_hung", bus.eng_hung, 0);
    ARESETN = 1'b1;
    step(1);
    checkOutput("idle_busy", bus.busy, 0);

    // Single write burst from requester 2, completed after 20 cycles.
    setReq(2, 1'b1, 32'h1000, 8'd15);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    step(1);
    checkOutput("t1_ready", bus.req_ready, 4'b0100);
    checkOutput("t1_start", bus.eng_start, 1);
    checkOutput("t1_addr", bus.eng_addr, 32'h1000);
    checkOutput("t1_len", bus.eng_len, 15);
    checkOutput("t1_wr", bus.eng_wr, 1);
    checkOutput("t1_grant", bus.grant_id, 2);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(19);
    checkOutput("t1_wait_busy", bus.busy, 1);
    checkOutput("t1_wait_done", bus.req_done, 0);
    checkOutput("t1_wait_addr", bus.eng_addr, 32'h1000);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(1);
    checkOutput("t1_done", bus.req_done, 4'b0100);
    checkOutput("t1_error", bus.req_error, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);
    checkOutput("t1_idle_busy", bus.busy, 0);
    checkOutput("t1_idle_done", bus.req_done, 0);

    // All four requesters held: rotation 0,1,2,3,0 from a fresh pointer.
    ARESETN = 1'b0;
    step(1);
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) setReq(i, i[0], 32'h2000 + 32'(i) * 32'h100, 8'(i + 1));
    applyStimulus(4'b1111, 1'b0, 1'b0);
    p0 = ready_pulses;
    for (int g = 0; g < 5; g++) begin
      step(1);
      checkOutput("t2_grant", bus.grant_id, g % 4);
      checkOutput("t2_ready", bus.req_ready, 64'd1 << (g % 4));
      checkOutput("t2_addr", bus.eng_addr, 32'h2000 + 32'(g % 4) * 32'h100);
      step(4);
      checkOutput("t2_wait_ready", bus.req_ready, 0);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      step(1);
      checkOutput("t2_done", bus.req_done, 64'd1 << (g % 4));
      applyStimulus(4'b1111, 1'b0, 1'b0);
      step(1);
      checkOutput("t2_idle_busy", bus.busy, 0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t2_ready_count", 64'(ready_pulses - p0), 5);

    // Bus error on requester 1, stray eng_error without eng_done ignored, then grant 0.
    setReq(1, 1'b0, 32'h3000, 8'd3);
    setReq(0, 1'b1, 32'h4000, 8'd7);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    step(1);
    checkOutput("t3_grant", bus.grant_id, 1);
    checkOutput("t3_ready", bus.req_ready, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    step(1);
    checkOutput("t3_stray_err_busy", bus.busy, 1);
    checkOutput("t3_stray_err_done", bus.req_done, 0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step(1);
    checkOutput("t3_done", bus.req_done, 4'b0010);
    checkOutput("t3_error", bus.req_error, 4'b0010);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step(2);
    checkOutput("t3_next_grant", bus.grant_id, 0);
    checkOutput("t3_next_ready", bus.req_ready, 4'b0001);
    checkOutput("t3_next_len", bus.eng_len, 7);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(1);
    checkOutput("t3_next_done", bus.req_done, 4'b0001);
    checkOutput("t3_next_error", bus.req_error, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);

    // Watchdog expiry with timeout 10, drain until the late completion.
    bus.timeout_cfg = 16'd10;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step(1);
    checkOutput("t4_ready", bus.req_ready, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(10);
    checkOutput("t4_pre_expiry_done", bus.req_done, 0);
    step(1);
    checkOutput("t4_to_done", bus.req_done, 4'b0001);
    checkOutput("t4_to_error", bus.req_error, 4'b0001);
    checkOutput("t4_resp_hung", bus.eng_hung, 0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step(1);
    checkOutput("t4_hung", bus.eng_hung, 1);
    step(3);
    checkOutput("t4_hung_hold", bus.eng_hung, 1);
    checkOutput("t4_hung_no_grant", bus.req_ready, 0);
    checkOutput("t4_hung_busy", bus.busy, 1);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    step(1);
    checkOutput("t4_unhung", bus.eng_hung, 0);
    checkOutput("t4_late_done_discard", bus.req_done, 0);
    checkOutput("t4_late_err_discard", bus.req_error, 0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step(1);
    checkOutput("t4_regrant", bus.req_ready, 4'b0001);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(1);
    checkOutput("t4_start_done", bus.req_done, 4'b0001);
    checkOutput("t4_start_error", bus.req_error, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);

    // eng_done on the expiry cycle beats the watchdog.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    step(1);
    checkOutput("t5_grant", bus.grant_id, 2);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(10);
    checkOutput("t5_pre_done", bus.req_done, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(1);
    checkOutput("t5_done", bus.req_done, 4'b0100);
    checkOutput("t5_error", bus.req_error, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);
    checkOutput("t5_no_drain", bus.eng_hung, 0);
    checkOutput("t5_idle", bus.busy, 0);

    // Asynchronous reset in WAIT, then the pointer restarts at 0.
    bus.timeout_cfg = 16'd100;
    setReq(3, 1'b1, 32'h5000, 8'd9);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    step(1);
    checkOutput("t6_grant", bus.grant_id, 3);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(3);
    #2 ARESETN = 1'b0;
    #1;
    checkOutput("t6_async_busy", bus.busy, 0);
    checkOutput("t6_async_grant", bus.grant_id, 0);
    checkOutput("t6_async_addr", bus.eng_addr, 0);
    checkOutput("t6_async_wr", bus.eng_wr, 0);
    checkOutput("t6_async_done", bus.req_done, 0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    step(1);
    ARESETN = 1'b1;
    step(1);
    checkOutput("t6_regrant", bus.grant_id, 1);
    checkOutput("t6_reready", bus.req_ready, 4'b0010);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(1);
    checkOutput("t6_done", bus.req_done, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
